// File: rtl/pipe_pkg.sv
// Shared Y86-64 pipeline definitions: icodes, status codes, control-unit states
// and the exception-status check used across the pipeline stages.
package pipe_pkg;

  localparam logic [3:0] ICODE_NOP    = 4'h1;
  localparam logic [3:0] ICODE_MRMOVQ = 4'h5;
  localparam logic [3:0] ICODE_OPQ    = 4'h6;
  localparam logic [3:0] ICODE_JXX    = 4'h7;
  localparam logic [3:0] ICODE_RET    = 4'h9;
  localparam logic [3:0] ICODE_POPQ   = 4'hB;
  localparam logic [3:0] REG_NONE     = 4'hF;

  localparam logic [2:0] STAT_BUB = 3'd0;
  localparam logic [2:0] STAT_AOK = 3'd1;
  localparam logic [2:0] STAT_HLT = 3'd2;
  localparam logic [2:0] STAT_ADR = 3'd3;
  localparam logic [2:0] STAT_INS = 3'd4;

  typedef enum logic [1:0] {
    ST_FLUSH = 2'd0,
    ST_RUN   = 2'd1,
    ST_HALT  = 2'd2
  } ctrl_state_e;

  typedef struct packed {
    logic f_stall;
    logic d_stall;
    logic d_bubble;
    logic e_bubble;
    logic m_bubble;
    logic w_stall;
    logic set_cc;
    logic halted;
  } pipe_ctl_t;

  function automatic logic is_exc(input logic [2:0] stat);
    logic exc;
    case (stat)
      STAT_HLT: exc = 1'b1;
      STAT_ADR: exc = 1'b1;
      STAT_INS: exc = 1'b1;
      default:  exc = 1'b0;
    endcase
    return exc;
  endfunction

endpackage

// File: rtl/pipe_hazard_detect.sv
// Combinational hazard detection: load/use interlock, in-flight RET and
// mispredicted conditional jump.
module pipe_hazard_detect
  import pipe_pkg::*;
(
  input  logic [3:0] i_d_icode,
  input  logic [3:0] i_d_src_a,
  input  logic [3:0] i_d_src_b,
  input  logic [3:0] i_e_icode,
  input  logic [3:0] i_e_dest_m,
  input  logic       i_e_cnd,
  input  logic [3:0] i_m_icode,
  output logic       o_load_use,
  output logic       o_ret_inflight,
  output logic       o_mispredict
);

  logic w_e_is_load;

  assign w_e_is_load    = (i_e_icode == ICODE_MRMOVQ) || (i_e_icode == ICODE_POPQ);
  assign o_load_use     = w_e_is_load && (i_e_dest_m != REG_NONE) &&
                          ((i_e_dest_m == i_d_src_a) || (i_e_dest_m == i_d_src_b));
  assign o_ret_inflight = (i_d_icode == ICODE_RET) || (i_e_icode == ICODE_RET) ||
                          (i_m_icode == ICODE_RET);
  assign o_mispredict   = (i_e_icode == ICODE_JXX) && !i_e_cnd;

endmodule

// File: rtl/pipe_ctrl.sv
// Y86-64 pipeline control: stall/bubble generation, post-reset flush, halt on
// retiring exception. Performance counters are built only with PIPE_CTRL_PERF_EN.
module pipe_ctrl
  import pipe_pkg::*;
#(
  parameter int unsigned FLUSH_CYCLES = 5,
  parameter int unsigned CNT_W        = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [3:0]       D_icode,
  input  logic [3:0]       d_srcA,
  input  logic [3:0]       d_srcB,
  input  logic [3:0]       E_icode,
  input  logic [3:0]       E_destM,
  input  logic             e_cnd,
  input  logic [3:0]       M_icode,
  input  logic [2:0]       m_stat,
  input  logic [2:0]       W_stat,
  input  logic [3:0]       W_icode,
  output logic             F_stall,
  output logic             D_stall,
  output logic             D_bubble,
  output logic             E_bubble,
  output logic             M_bubble,
  output logic             W_stall,
  output logic             set_cc,
  output logic             halted,
  output logic [2:0]       final_stat,
  output logic [CNT_W-1:0] cycle_count,
  output logic [CNT_W-1:0] retired_count
);

  localparam int unsigned      FC_W       = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
  localparam logic [FC_W-1:0]  FLUSH_INIT = FC_W'(FLUSH_CYCLES - 32'd1);
  localparam logic [FC_W-1:0]  FC_ZERO    = {FC_W{1'b0}};
  localparam logic [FC_W-1:0]  FC_ONE     = {{(FC_W-1){1'b0}}, 1'b1};

  ctrl_state_e      r_state;
  ctrl_state_e      w_next_state;
  logic [FC_W-1:0]  r_flush_cnt;
  logic [2:0]       r_final_stat;
  pipe_ctl_t        w_ctl;
  logic             w_load_use;
  logic             w_ret_inflight;
  logic             w_mispredict;
  logic             w_m_exc;
  logic             w_w_exc;

  pipe_hazard_detect u_hazard (
    .i_d_icode      (D_icode),
    .i_d_src_a      (d_srcA),
    .i_d_src_b      (d_srcB),
    .i_e_icode      (E_icode),
    .i_e_dest_m     (E_destM),
    .i_e_cnd        (e_cnd),
    .i_m_icode      (M_icode),
    .o_load_use     (w_load_use),
    .o_ret_inflight (w_ret_inflight),
    .o_mispredict   (w_mispredict)
  );

  assign w_m_exc = is_exc(m_stat);
  assign w_w_exc = is_exc(W_stat);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_FLUSH;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state logic; HALT is left only through reset
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_FLUSH: begin
        if (r_flush_cnt == FC_ZERO) begin
          w_next_state = ST_RUN;
        end else begin
          w_next_state = ST_FLUSH;
        end
      end
      ST_RUN: begin
        if (w_w_exc) begin
          w_next_state = ST_HALT;
        end else begin
          w_next_state = ST_RUN;
        end
      end
      ST_HALT: w_next_state = ST_HALT;
      default: w_next_state = ST_FLUSH;
    endcase
  end

  // Flush down-counter: loaded at reset, FLUSH ends on the edge that sees zero
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_flush_cnt <= FLUSH_INIT;
    end else if ((r_state == ST_FLUSH) && (r_flush_cnt != FC_ZERO)) begin
      r_flush_cnt <= r_flush_cnt - FC_ONE;
    end else begin
      r_flush_cnt <= r_flush_cnt;
    end
  end

  // Capture the status of the instruction that froze the pipeline
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_final_stat <= STAT_AOK;
    end else if ((r_state == ST_RUN) && w_w_exc) begin
      r_final_stat <= W_stat;
    end else begin
      r_final_stat <= r_final_stat;
    end
  end

  // Control outputs; load_use beats ret_inflight for D, and the D register
  // gives bubble priority over stall when mispredict meets load_use
  always_comb begin
    w_ctl = '0;
    case (r_state)
      ST_FLUSH: begin
        w_ctl.f_stall  = 1'b1;
        w_ctl.d_bubble = 1'b1;
        w_ctl.e_bubble = 1'b1;
        w_ctl.m_bubble = 1'b1;
      end
      ST_RUN: begin
        w_ctl.f_stall  = w_load_use || w_ret_inflight;
        w_ctl.d_stall  = w_load_use;
        w_ctl.d_bubble = w_mispredict || (!w_load_use && w_ret_inflight);
        w_ctl.e_bubble = w_mispredict || w_load_use;
        w_ctl.m_bubble = w_m_exc || w_w_exc;
        w_ctl.w_stall  = w_w_exc;
        w_ctl.set_cc   = (E_icode == ICODE_OPQ) && !w_m_exc && !w_w_exc;
      end
      ST_HALT: begin
        w_ctl.f_stall  = 1'b1;
        w_ctl.d_stall  = 1'b1;
        w_ctl.e_bubble = 1'b1;
        w_ctl.m_bubble = 1'b1;
        w_ctl.w_stall  = 1'b1;
        w_ctl.halted   = 1'b1;
      end
      default: begin
        w_ctl.f_stall  = 1'b1;
        w_ctl.d_bubble = 1'b1;
        w_ctl.e_bubble = 1'b1;
        w_ctl.m_bubble = 1'b1;
      end
    endcase
  end

  assign F_stall    = w_ctl.f_stall;
  assign D_stall    = w_ctl.d_stall;
  assign D_bubble   = w_ctl.d_bubble;
  assign E_bubble   = w_ctl.e_bubble;
  assign M_bubble   = w_ctl.m_bubble;
  assign W_stall    = w_ctl.w_stall;
  assign set_cc     = w_ctl.set_cc;
  assign halted     = w_ctl.halted;
  assign final_stat = r_final_stat;

`ifdef PIPE_CTRL_PERF_EN
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [CNT_W-1:0] r_cycle_count;
  logic [CNT_W-1:0] r_retired_count;

  // Run-time counters; the EXC instruction never satisfies the AOK retire test
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cycle_count   <= CNT_ZERO;
      r_retired_count <= CNT_ZERO;
    end else if (r_state == ST_RUN) begin
      r_cycle_count <= r_cycle_count + CNT_ONE;
      if ((W_stat == STAT_AOK) && (W_icode != ICODE_NOP)) begin
        r_retired_count <= r_retired_count + CNT_ONE;
      end else begin
        r_retired_count <= r_retired_count;
      end
    end else begin
      r_cycle_count   <= r_cycle_count;
      r_retired_count <= r_retired_count;
    end
  end

  assign cycle_count   = r_cycle_count;
  assign retired_count = r_retired_count;
`else
  logic w_perf_unused;

  assign w_perf_unused = ^W_icode;
  assign cycle_count   = {CNT_W{1'b0}};
  assign retired_count = {CNT_W{1'b0}};
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Scoreboard bench for pipe_ctrl: directed hazard scenarios plus randomized
// traffic, checked against a cycle-level behavioural model.
module tb_pipe_ctrl;
  import pipe_pkg::*;

  localparam int FC = 5;
`ifdef PIPE_CTRL_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  D_icode, d_srcA, d_srcB, E_icode, E_destM, M_icode, W_icode;
  logic        e_cnd;
  logic [2:0]  m_stat, W_stat;
  logic        F_stall, D_stall, D_bubble, E_bubble, M_bubble, W_stall, set_cc, halted;
  logic [2:0]  final_stat;
  logic [31:0] cycle_count, retired_count;

  always #5 clk = ~clk;

  pipe_ctrl #(.FLUSH_CYCLES(FC), .CNT_W(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .D_icode(D_icode), .d_srcA(d_srcA), .d_srcB(d_srcB),
    .E_icode(E_icode), .E_destM(E_destM), .e_cnd(e_cnd),
    .M_icode(M_icode), .m_stat(m_stat), .W_stat(W_stat), .W_icode(W_icode),
    .F_stall(F_stall), .D_stall(D_stall), .D_bubble(D_bubble), .E_bubble(E_bubble),
    .M_bubble(M_bubble), .W_stall(W_stall), .set_cc(set_cc), .halted(halted),
    .final_stat(final_stat), .cycle_count(cycle_count), .retired_count(retired_count)
  );

  typedef struct {
    logic [7:0]  ctl;
    logic [2:0]  fstat;
    logic [31:0] cyc;
    logic [31:0] ret;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  // pending stimulus for the next cycle
  logic       p_rn, p_ec;
  logic [3:0] p_di, p_sa, p_sb, p_ei, p_edm, p_mi, p_wi;
  logic [2:0] p_ms, p_ws;

  // reference model: 0 = flushing, 1 = running, 2 = frozen
  int          m_mode;
  int          m_flush_left;
  logic [2:0]  m_fstat;
  logic [31:0] m_cyc, m_ret;

  function automatic bit exc(input logic [2:0] s);
    return (s == 3'd2) || (s == 3'd3) || (s == 3'd4);
  endfunction

  task automatic model_reset();
    m_mode = 0; m_flush_left = FC; m_fstat = 3'd1; m_cyc = 32'd0; m_ret = 32'd0;
  endtask

  // advance the model across one rising edge using the inputs held during the cycle
  task automatic model_edge();
    if (m_mode == 0) begin
      m_flush_left = m_flush_left - 1;
      if (m_flush_left == 0) m_mode = 1;
    end else if (m_mode == 1) begin
      if (PERF) begin
        m_cyc = m_cyc + 32'd1;
        if (W_stat == 3'd1 && W_icode != 4'h1) m_ret = m_ret + 32'd1;
      end
      if (exc(W_stat)) begin
        m_mode = 2;
        m_fstat = W_stat;
      end
    end
  endtask

  // {F_stall, D_stall, D_bubble, E_bubble, M_bubble, W_stall, set_cc, halted}
  function automatic logic [7:0] ref_ctl();
    bit lu, rt, mp;
    lu = (E_icode == 4'h5 || E_icode == 4'hB) && E_destM != 4'hF &&
         (E_destM == d_srcA || E_destM == d_srcB);
    rt = (D_icode == 4'h9) || (E_icode == 4'h9) || (M_icode == 4'h9);
    mp = (E_icode == 4'h7) && !e_cnd;
    if (m_mode == 0) return 8'b1_0_1_1_1_0_0_0;
    if (m_mode == 2) return 8'b1_1_0_1_1_1_0_1;
    return {lu | rt, lu, mp | (!lu & rt), mp | lu, exc(m_stat) | exc(W_stat),
            exc(W_stat), (E_icode == 4'h6) & !exc(m_stat) & !exc(W_stat), 1'b0};
  endfunction

  task automatic push_expected();
    exp_t e;
    e.ctl = ref_ctl(); e.fstat = m_fstat; e.cyc = m_cyc; e.ret = m_ret;
    sb_q.push_back(e);
  endtask

  task automatic set_idle();
    p_rn = 1'b1; p_di = 4'h1; p_sa = 4'hF; p_sb = 4'hF; p_ei = 4'h1; p_edm = 4'hF;
    p_ec = 1'b1; p_mi = 4'h1; p_ms = 3'd1; p_ws = 3'd1; p_wi = 4'h1;
  endtask

  task automatic tick();
    @(posedge clk);
    if (rst_n) model_edge();
    #2;
    rst_n = p_rn; D_icode = p_di; d_srcA = p_sa; d_srcB = p_sb; E_icode = p_ei;
    E_destM = p_edm; e_cnd = p_ec; M_icode = p_mi; m_stat = p_ms; W_stat = p_ws;
    W_icode = p_wi;
    if (!p_rn) model_reset();
    push_expected();
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    n_checks++;
    if (act === exp_v) n_pass++;
    else $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp_v);
  endtask

  // monitor: compare every queued expectation against the outputs mid-cycle
  always @(negedge clk) begin
    while (sb_q.size() > 0) begin
      exp_t e;
      e = sb_q.pop_front();
      check("ctrl", {24'd0, F_stall, D_stall, D_bubble, E_bubble, M_bubble, W_stall,
                     set_cc, halted}, {24'd0, e.ctl});
      check("final_stat", {29'd0, final_stat}, {29'd0, e.fstat});
      check("cycle_count", cycle_count, e.cyc);
      check("retired_count", retired_count, e.ret);
    end
  end

  logic [3:0] ic_tab [8] = '{4'h0, 4'h1, 4'h5, 4'h6, 4'h7, 4'h9, 4'hB, 4'h2};
  logic [3:0] rg_tab [4] = '{4'h3, 4'h4, 4'h5, 4'hF};

  function automatic logic [2:0] rand_stat(input int exc_pct);
    int r;
    r = $urandom_range(0, 99);
    if (r < exc_pct) return 3'($urandom_range(2, 4));
    if (r < exc_pct + 15) return 3'd0;
    return 3'd1;
  endfunction

  initial begin
    set_idle();
    p_rn = 1'b0;
    rst_n = 1'b0; D_icode = 4'h1; d_srcA = 4'hF; d_srcB = 4'hF; E_icode = 4'h1;
    E_destM = 4'hF; e_cnd = 1'b1; M_icode = 4'h1; m_stat = 3'd1; W_stat = 3'd1;
    W_icode = 4'h1;
    model_reset();
    #1 push_expected();
    tick(); tick();

    // flush window then idle run
    set_idle();
    repeat (8) tick();

    // load/use interlock, then non-matching source
    p_ei = 4'h5; p_edm = 4'h3; p_sa = 4'h3; tick();
    p_sa = 4'h4; tick();
    p_ei = 4'hB; p_edm = 4'h5; p_sb = 4'h5; tick();
    p_edm = 4'hF; p_sa = 4'hF; p_sb = 4'hF; tick();
    set_idle();

    // jump mispredict and correct prediction
    p_ei = 4'h7; p_ec = 1'b0; tick();
    p_ec = 1'b1; tick();
    set_idle();

    // RET moving through D, E, M; then RET together with load/use
    p_di = 4'h9; tick();
    p_di = 4'h1; p_ei = 4'h9; tick();
    p_ei = 4'h1; p_mi = 4'h9; tick();
    p_ei = 4'h5; p_edm = 4'h2; p_sa = 4'h2; p_di = 4'h9; p_mi = 4'h1; tick();
    p_di = 4'h1; p_mi = 4'h9; tick();
    set_idle();

    // condition codes gated by a memory-stage exception
    p_ei = 4'h6; tick();
    p_ms = 3'd3; tick();
    set_idle();

    // retirement mix: 4 AOK non-NOP, 2 bubbles, 4 AOK NOPs
    for (int i = 0; i < 10; i++) begin
      p_ws = (i == 4 || i == 5) ? 3'd0 : 3'd1;
      p_wi = (i < 4) ? 4'h6 : 4'h1;
      tick();
    end
    set_idle();

    // exception retires: freeze pipeline
    p_ws = 3'd3; p_wi = 4'h5; tick();
    set_idle();
    repeat (4) tick();

    // asynchronous reset from HALT, observed before any clock edge
    p_rn = 1'b0; tick();

    // randomized traffic with occasional mid-run resets
    for (int r = 0; r < 4; r++) begin
      set_idle(); p_rn = 1'b0; tick(); tick();
      for (int c = 0; c < 80; c++) begin
        p_rn  = ($urandom_range(0, 59) != 0);
        p_di  = ic_tab[$urandom_range(0, 7)];
        p_ei  = ic_tab[$urandom_range(0, 7)];
        p_mi  = ic_tab[$urandom_range(0, 7)];
        p_wi  = ic_tab[$urandom_range(0, 7)];
        p_sa  = rg_tab[$urandom_range(0, 3)];
        p_sb  = rg_tab[$urandom_range(0, 3)];
        p_edm = rg_tab[$urandom_range(0, 3)];
        p_ec  = 1'($urandom_range(0, 1));
        p_ms  = rand_stat(4);
        p_ws  = rand_stat(2);
        tick();
      end
    end

    set_idle();
    tick();
    for (int w = 0; w < 5 && sb_q.size() > 0; w++) @(negedge clk);
    @(posedge clk);
    n_checks++;
    if (sb_q.size() == 0) n_pass++;
    else $display("FAIL drain: %0d entries left, expected 0", sb_q.size());
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/pipe_ctrl.md
# pipe_ctrl

Pipeline control unit for the five-stage Y86-64 processor. It watches the decode, execute, memory and writeback pipeline registers and drives the stall/bubble controls of the F, D, E, M and W pipeline registers. It also gates condition-code updates. Its sequential part flushes the unreset pipeline registers after reset, freezes the pipeline once a non-AOK status retires, and keeps optional performance counters.

## Interface
- FLUSH_CYCLES, 5: cycles spent in FLUSH after reset release (≥1).
- CNT_W, 32: width of cycle/retire counters.

- clk  in  1  pipeline clock, rising edge.
- rst_n  in  1  reset; one clock, reset is asynchronous and active-low.
- D_icode  in  4  icode in D register.
- d_srcA, d_srcB  in  4 each  decode source registers (0xF = none).
- E_icode  in  4  icode in E register.
- E_destM  in  4  load destination in E.
- e_cnd  in  1  branch condition from execute.
- M_icode  in  4  icode in M register.
- m_stat  in  3  memory-stage status.
- W_stat  in  3  writeback status.
- W_icode  in  4  writeback icode.
- F_stall, D_stall, D_bubble, E_bubble, M_bubble, W_stall  out  1 each  pipeline register controls.
- set_cc  out  1  permit CC write in execute.
- halted  out  1  pipeline frozen.
- final_stat  out  3  latched retiring status.
- cycle_count, retired_count  out  CNT_W each  performance counters.

## Operation
- Status codes: BUB=0, AOK=1, HLT=2, ADR=3, INS=4; EXC means HLT, ADR or INS.
- icodes used: NOP=1, MRMOVQ=5, OPQ=6, JXX=7, RET=9, POPQ=B.
- load_use = E_icode∈{MRMOVQ,POPQ} && E_destM≠0xF && E_destM∈{d_srcA,d_srcB}.
- ret_inflight = RET∈{D_icode,E_icode,M_icode}.
- mispredict = E_icode==JXX && !e_cnd.
- States: FLUSH, RUN, HALT.

FLUSH (entered on reset):
- Outputs: F_stall=1, D_bubble=E_bubble=M_bubble=1, D_stall=0, W_stall=0, set_cc=0.
- A down-counter loads FLUSH_CYCLES−1. Transition to RUN when it reaches 0.

RUN, standard Y86 rules:
- F_stall = load_use || ret_inflight.
- D_stall = load_use.
- D_bubble = mispredict || (!load_use && ret_inflight).
- E_bubble = mispredict || load_use.
- M_bubble = m_stat∈EXC || W_stat∈EXC.
- W_stall = W_stat∈EXC.
- set_cc = E_icode==OPQ && m_stat∉EXC && W_stat∉EXC.
- RUN→HALT when W_stat∈EXC. final_stat ← W_stat on that edge.

HALT:
- Outputs: F_stall=D_stall=W_stall=1, E_bubble=M_bubble=1, D_bubble=0, set_cc=0, halted=1.
- HALT exits only through reset.

Counters:
- cycle_count increments every cycle in RUN.
- retired_count increments in RUN when W_stat==AOK && W_icode≠NOP.
- Both wrap modulo 2^CNT_W.

## Timing
- All control outputs are combinational from inputs and the current state, valid in the same cycle.
- State, final_stat and counters update on the rising clk edge.
- Reset values: state=FLUSH, final_stat=AOK, halted=0, counters=0. Control outputs take their FLUSH values immediately on rst_n low, regardless of the clock.
- Reset asserted mid-RUN or in HALT returns to FLUSH immediately.
- FLUSH lasts exactly FLUSH_CYCLES rising edges after rst_n deasserts. The first RUN cycle is edge FLUSH_CYCLES+1.
- load_use together with ret_inflight: load_use wins. D_stall=1, D_bubble=0, E_bubble=1.
- mispredict together with load_use: E_bubble=1 and D_bubble=1, D_stall=1. The register must treat bubble as having priority over stall.
- The HALT transition edge does not count the EXC instruction as retired.

## Configuration
- PIPE_CTRL_PERF_EN defined: cycle_count and retired_count are implemented as described.
- PIPE_CTRL_PERF_EN undefined: no counter flops are built, and both outputs are tied to 0.

## Structure
- The shared package pipe_pkg holds the icode constants, the stat constants and the EXC check function. The fetch, decode, execute, memory and writeback stages use the same package.
- Sub-module pipe_hazard_detect is purely combinational and computes load_use, ret_inflight and mispredict.
- The FSM, flush counter and perf counters stay in pipe_ctrl.

## Test plan
1. Reset, then hold all icodes at NOP, FLUSH_CYCLES=5 → F_stall=1 for 5 edges, first RUN cycle on edge 6, cycle_count=1 after edge 6.
2. E_icode=MRMOVQ, E_destM=3, d_srcA=3 → F_stall=1, D_stall=1, E_bubble=1, D_bubble=0. With d_srcA=4 instead → all controls 0.
3. E_icode=JXX, e_cnd=0 → D_bubble=1, E_bubble=1. With e_cnd=1 → both 0.
4. D_icode=RET, then M_icode=RET over successive cycles → F_stall=1 and D_bubble=1 for each cycle. Repeat with a simultaneous load_use → D_bubble=0, D_stall=1.
5. W_stat=ADR in RUN → W_stall=1 and M_bubble=1 the same cycle. The next edge gives HALT, halted=1, final_stat=3, and the counters stop.
6. Run 10 cycles with 4 AOK non-NOP retirements and 2 bubbles → retired_count=4. Build without PIPE_CTRL_PERF_EN → both counters read 0.
